text_entry_buffer: RTL

- Upstream feeder for the on-screen text renderer: collects decoded ASCII keystrokes into an editable line buffer.
- Publishes the committed line as a packed string, a character count and a one-cycle ready strobe.
- Publication happens only at a frame boundary, so the renderer never swaps text mid-frame.
- Output string/numchar/ready connect directly to the renderer's string/numchar/ready inputs.

---
 rtl/text_entry_buffer_pkg.sv | 31 +++
 rtl/text_entry_buffer_key_classifier.sv | 28 ++
 rtl/text_entry_buffer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/text_entry_buffer_pkg.sv
// Shared ASCII constants, key classes and FSM encoding for the text entry buffer.
package text_entry_buffer_pkg;

   localparam logic [7:0] KEY_BS      = 8'h08;
   localparam logic [7:0] KEY_CR      = 8'h0D;
   localparam logic [7:0] KEY_ESC     = 8'h1B;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] UPPER_A     = 8'h41;
   localparam logic [7:0] UPPER_Z     = 8'h5A;
   localparam logic [7:0] LOWER_A     = 8'h61;
   localparam logic [7:0] LOWER_Z     = 8'h7A;
   localparam logic [7:0] CASE_OFFSET = 8'h20;

   localparam logic [1:0] S_EDIT    = 2'd0;
   localparam logic [1:0] S_PENDING = 2'd1;
   localparam logic [1:0] S_PUBLISH = 2'd2;

   typedef enum logic [2:0] {
      KC_APPEND,
      KC_BACKSPACE,
      KC_CLEAR,
      KC_COMMIT,
      KC_INVALID
   } key_class_e;

   function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                     input logic [7:0] hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/text_entry_buffer_key_classifier.sv
// Combinational keystroke decode: edit class plus the upper-case-folded byte to store.
module text_entry_buffer_key_classifier
   import text_entry_buffer_pkg::*;
(
   input  logic [7:0] key_code,
   output key_class_e key_class,
   output logic [7:0] key_char
);

   always_comb begin
      key_class = KC_INVALID;
      key_char  = key_code;
      if (in_range(key_code, UPPER_A, UPPER_Z) || key_code == ASCII_SPACE) begin
         key_class = KC_APPEND;
      end else if (in_range(key_code, LOWER_A, LOWER_Z)) begin
         key_class = KC_APPEND;
         key_char  = key_code - CASE_OFFSET;
      end else begin
         case (key_code)
            KEY_BS:  key_class = KC_BACKSPACE;
            KEY_ESC: key_class = KC_CLEAR;
            KEY_CR:  key_class = KC_COMMIT;
            default: key_class = KC_INVALID;
         endcase
      end
   end

endmodule

// File: rtl/text_entry_buffer.sv
// Line editor feeding the text renderer; the committed line is published only at a
// frame boundary so the renderer never swaps text mid-frame.
module text_entry_buffer
   import text_entry_buffer_pkg::*;
#(
   parameter int MAX_CHARS = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   key_valid,
   input  logic [7:0]             key_code,
   input  logic                   frame_start,
   output logic [MAX_CHARS*8-1:0] out_string,
   output logic [5:0]             numchar,
   output logic                   ready,
   output logic [5:0]             edit_len,
   output logic                   busy,
   output logic                   reject
);

   localparam logic [5:0] MAX_LEN = 6'(MAX_CHARS);

   key_class_e key_class;
   logic [7:0] key_char;

   text_entry_buffer_key_classifier u_key_classifier (
      .key_code  (key_code),
      .key_class (key_class),
      .key_char  (key_char)
   );

   logic [7:0]             edit_q [MAX_CHARS];
   logic [7:0]             edit_d [MAX_CHARS];
   logic [5:0]             len_q, len_d;
   logic [1:0]             state_q, state_d;
   logic [MAX_CHARS*8-1:0] string_q, string_d;
   logic [5:0]             numchar_q, numchar_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
   logic                   reject_q, reject_d;

   logic       wr_en;
   logic [5:0] wr_idx;
   logic [7:0] wr_byte;
   logic       clr_all;

   always_comb begin
      // NOTE: every variable gets a default here first so no path can infer a latch.
      state_d   = state_q;
      edit_d    = edit_q;
      len_d     = len_q;
      string_d  = string_q;
      numchar_d = numchar_q;
      busy_d    = busy_q;
      ready_d   = 1'b0;
      reject_d  = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = len_q;
      wr_byte   = key_char;
      clr_all   = 1'b0;

      case (state_q)
         S_EDIT: begin
            if (key_valid) begin
               case (key_class)
                  KC_APPEND: begin
                     if (len_q == MAX_LEN) begin
                        reject_d = 1'b1;
                     end else begin
                        wr_en = 1'b1;
                        len_d = len_q + 6'd1;
                     end
                  end
                  KC_BACKSPACE: begin
                     if (len_q == 6'd0) begin
                        reject_d = 1'b1;
                     end else begin
                        wr_en   = 1'b1;
                        wr_idx  = len_q - 6'd1;
                        wr_byte = ASCII_SPACE;
                        len_d   = len_q - 6'd1;
                     end
                  end
                  KC_CLEAR: begin
                     clr_all = 1'b1;
                     len_d   = 6'd0;
                  end
                  KC_COMMIT: begin
                     state_d = S_PENDING;
                     busy_d  = 1'b1;
                  end
                  default: reject_d = 1'b1;
               endcase
            end
         end
         S_PENDING: begin
            reject_d = key_valid;
            if (frame_start) state_d = S_PUBLISH;
         end
         S_PUBLISH: begin
            reject_d  = key_valid;
            numchar_d = len_q;
            ready_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_EDIT;
            for (int i = 0; i < MAX_CHARS; i++) begin
               string_d[(MAX_CHARS-1-i)*8 +: 8] = edit_q[i];
            end
         end
         default: begin
            state_d = S_EDIT;
            busy_d  = 1'b0;
         end
      endcase

      // Slots at or beyond len are kept at space so the published string needs no masking.
      for (int i = 0; i < MAX_CHARS; i++) begin
         if (clr_all) edit_d[i] = ASCII_SPACE;
         else if (wr_en && 6'(i) == wr_idx) edit_d[i] = wr_byte;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the edit buffer is reset too; the space-fill invariant depends on it.
         edit_q    <= '{default: ASCII_SPACE};
         len_q     <= 6'd0;
         state_q   <= S_EDIT;
         string_q  <= {MAX_CHARS{ASCII_SPACE}};
         numchar_q <= 6'd0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         reject_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         edit_q    <= edit_d;
         len_q     <= len_d;
         state_q   <= state_d;
         string_q  <= string_d;
         numchar_q <= numchar_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         reject_q  <= reject_d;
      end
   end

   assign out_string = string_q;
   assign numchar    = numchar_q;
   assign ready      = ready_q;
   assign edit_len   = len_q;
   assign busy       = busy_q;
   assign reject     = reject_q;

endmodule
